lcd1602_emu: RTL and testbench

LCD1602_EMU -- requirements
Module: lcd1602_emu

---
 rtl/lcd1602_emu_if.sv | 12 +
 rtl/lcd1602_emu.sv | 156 +++++++++++++++
 tb/tb_lcd1602_emu.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd1602_emu_if.sv
// HD44780-style parallel bus between an LCD host (master) and the emulator (slave).
interface lcd1602_emu_if;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic [7:0] rd_data;
   logic       rd_oe;

   modport master (output lcd_data, lcd_rs, lcd_rw, lcd_e, input rd_data, rd_oe);
   modport slave  (input lcd_data, lcd_rs, lcd_rw, lcd_e, output rd_data, rd_oe);
endinterface

// File: rtl/lcd1602_emu.sv
// Cycle-based emulation of a 16x2 HD44780 character LCD: instruction decode, DDRAM,
// address counter and busy flag. Bus strobes are synchronized into clk before use.
module lcd1602_emu #(
   parameter int BUSY_CYC = 4,
   parameter int CLR_BUSY = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   lcd1602_emu_if.slave   bus,
   output logic [127:0]   row1_val,
   output logic [127:0]   row2_val,
   output logic           disp_on,
   output logic           cursor_on,
   output logic           blink_on,
   output logic [6:0]     addr,
   output logic           busy,
   output logic           cmd_err
);
   localparam int MAX_B = (CLR_BUSY > BUSY_CYC) ? CLR_BUSY : BUSY_CYC;
   localparam int CW    = $clog2(MAX_B + 1);

   logic          e_s1_q, e_s2_q, e_s3_q;
   logic          rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
   logic [7:0]    data_s1_q, data_s2_q;
   logic [7:0]    cell_q [32];
   logic [7:0]    cell_d [32];
   logic [6:0]    ac_q, ac_d;
   logic          id_q, id_d, disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fall, ac_vis, dd_ok, rd_oe;
   logic [4:0]    ac_idx;
   logic [7:0]    rd_cell;

   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
      logic [6:0] r;
      if (inc) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      else     r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
      return r;
   endfunction

   assign fall    = e_s3_q & ~e_s2_q;
   assign busy    = (cnt_q != '0);
   assign ac_vis  = (ac_q[6:4] == 3'b000) || (ac_q[6:4] == 3'b100);
   assign ac_idx  = {ac_q[6], ac_q[3:0]};
   assign dd_ok   = (data_s2_q[6:0] <= 7'h27) ||
                    ((data_s2_q[6:0] >= 7'h40) && (data_s2_q[6:0] <= 7'h67));
   assign rd_cell = ac_vis ? cell_q[ac_idx] : 8'h20;
   assign rd_oe   = e_s2_q & rw_s2_q;

   assign bus.rd_oe   = rd_oe;
   assign bus.rd_data = !rd_oe ? 8'h00 : (rs_s2_q ? rd_cell : {busy, ac_q});

   assign addr      = ac_q;
   assign disp_on   = disp_q;
   assign cursor_on = cur_q;
   assign blink_on  = blink_q;
   assign cmd_err   = err_q;

   for (genvar i = 0; i < 16; i++) begin : g_pack
      assign row1_val[127-8*i -: 8] = cell_q[i];
      assign row2_val[127-8*i -: 8] = cell_q[16+i];
   end

   always_comb begin
      cell_d  = cell_q;
      ac_d    = ac_q;
      id_d    = id_q;
      disp_d  = disp_q;
      cur_d   = cur_q;
      blink_d = blink_q;
      err_d   = 1'b0;
      cnt_d   = busy ? cnt_q - CW'(1) : cnt_q;
      // Busy-flag reads never touch state; everything else is dropped while busy.
      if (fall && !(rw_s2_q && !rs_s2_q)) begin
         if (busy) begin
            err_d = 1'b1;
         end else if (rw_s2_q) begin
            ac_d = ac_step(ac_q, id_q);
         end else if (rs_s2_q) begin
            if (ac_vis) cell_d[ac_idx] = data_s2_q;
            ac_d  = ac_step(ac_q, id_q);
            cnt_d = CW'(BUSY_CYC);
         end else begin
            cnt_d = CW'(BUSY_CYC);
            casez (data_s2_q)
               8'b1???????: if (dd_ok) ac_d = data_s2_q[6:0]; else err_d = 1'b1;
               8'b01??????: err_d = 1'b1;
               8'b001?????: err_d = ~data_s2_q[4];
               8'b0001????: if (data_s2_q[3]) err_d = 1'b1;
                            else ac_d = ac_step(ac_q, data_s2_q[2]);
               8'b00001???: begin
                  disp_d  = data_s2_q[2];
                  cur_d   = data_s2_q[1];
                  blink_d = data_s2_q[0];
               end
               8'b000001??: begin
                  id_d  = data_s2_q[1];
                  err_d = data_s2_q[0];
               end
               8'b0000001?: begin
                  ac_d  = 7'h00;
                  cnt_d = CW'(CLR_BUSY);
               end
               8'b00000001: begin
                  for (int i = 0; i < 32; i++) cell_d[i] = 8'h20;
                  ac_d  = 7'h00;
                  id_d  = 1'b1;
                  cnt_d = CW'(CLR_BUSY);
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_s1_q    <= 1'b0;
         e_s2_q    <= 1'b0;
         e_s3_q    <= 1'b0;
         rs_s1_q   <= 1'b0;
         rs_s2_q   <= 1'b0;
         rw_s1_q   <= 1'b0;
         rw_s2_q   <= 1'b0;
         data_s1_q <= 8'h00;
         data_s2_q <= 8'h00;
         for (int i = 0; i < 32; i++) cell_q[i] <= 8'h20;
         ac_q      <= 7'h00;
         id_q      <= 1'b1;
         disp_q    <= 1'b0;
         cur_q     <= 1'b0;
         blink_q   <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         e_s1_q    <= bus.lcd_e;
         e_s2_q    <= e_s1_q;
         e_s3_q    <= e_s2_q;
         rs_s1_q   <= bus.lcd_rs;
         rs_s2_q   <= rs_s1_q;
         rw_s1_q   <= bus.lcd_rw;
         rw_s2_q   <= rw_s1_q;
         data_s1_q <= bus.lcd_data;
         data_s2_q <= data_s1_q;
         cell_q    <= cell_d;
         ac_q      <= ac_d;
         id_q      <= id_d;
         disp_q    <= disp_d;
         cur_q     <= cur_d;
         blink_q   <= blink_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule

// File: tb/tb_lcd1602_emu.sv
// Bench for lcd1602_emu: directed scenarios plus randomized bus traffic against an
// array-based model of the display memory, address counter and busy window.
module tb_lcd1602_emu;
   localparam int BUSY_CYC = 4;
   localparam int CLR_BUSY = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lcd1602_emu_if bus();
   logic [127:0] row1_val, row2_val;
   logic         disp_on, cursor_on, blink_on, busy, cmd_err;
   logic [6:0]   addr;

   lcd1602_emu #(.BUSY_CYC(BUSY_CYC), .CLR_BUSY(CLR_BUSY)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .row1_val(row1_val), .row2_val(row2_val),
      .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
      .addr(addr), .busy(busy), .cmd_err(cmd_err)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] m_cells [32];
   int         m_ac;
   bit         m_id, m_d, m_c, m_b;
   int         m_busy_last;

   function automatic void m_reset();
      for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
      m_ac = 0; m_id = 1'b1; m_d = 1'b0; m_c = 1'b0; m_b = 1'b0;
      m_busy_last = -100;
   endfunction

   function automatic int m_idx(int a);
      if (a < 16) return a;
      if (a >= 64 && a < 80) return a - 48;
      return -1;
   endfunction

   function automatic int m_step(int a, bit inc);
      if (inc) begin
         if (a == 39) return 64;
         if (a == 103) return 0;
         return a + 1;
      end
      if (a == 0) return 103;
      if (a == 64) return 39;
      return a - 1;
   endfunction

   function automatic logic [127:0] m_row(int r);
      logic [127:0] v;
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = m_cells[r*16+i];
      return v;
   endfunction

   // Applies one transfer whose write edge is clk edge 'eff'; returns expected cmd_err.
   function automatic bit m_apply(bit rs, bit rw, logic [7:0] d, int eff);
      int a, idx;
      if (rw && !rs) return 1'b0;
      if (eff - 1 <= m_busy_last) return 1'b1;
      if (rw) begin
         m_ac = m_step(m_ac, m_id);
         return 1'b0;
      end
      m_busy_last = eff + BUSY_CYC - 1;
      if (rs) begin
         idx = m_idx(m_ac);
         if (idx >= 0) m_cells[idx] = d;
         m_ac = m_step(m_ac, m_id);
         return 1'b0;
      end
      if (d == 8'h00) return 1'b0;
      if (d == 8'h01) begin
         for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
         m_ac = 0; m_id = 1'b1;
         m_busy_last = eff + CLR_BUSY - 1;
         return 1'b0;
      end
      if (d <= 8'h03) begin
         m_ac = 0;
         m_busy_last = eff + CLR_BUSY - 1;
         return 1'b0;
      end
      if (d <= 8'h07) begin
         m_id = d[1];
         return d[0];
      end
      if (d <= 8'h0F) begin
         m_d = d[2]; m_c = d[1]; m_b = d[0];
         return 1'b0;
      end
      if (d <= 8'h1F) begin
         if (d[3]) return 1'b1;
         m_ac = m_step(m_ac, d[2]);
         return 1'b0;
      end
      if (d <= 8'h3F) return !d[4];
      if (d <= 8'h7F) return 1'b1;
      a = int'(d) - 128;
      if (a <= 39 || (a >= 64 && a <= 103)) begin
         m_ac = a;
         return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic xfer(input bit rs, input bit rw, input logic [7:0] d, input int hold,
                       output int errs, output bit err_exp,
                       output logic [7:0] rd_seen, output logic [7:0] rd_exp);
      int idx;
      @(negedge clk);
      bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data = d; bus.lcd_e = 1'b1;
      repeat (hold) @(negedge clk);
      rd_seen = bus.rd_data;
      rd_exp  = 8'h00;
      if (rw) begin
         idx = m_idx(m_ac);
         if (rs) rd_exp = (idx >= 0) ? m_cells[idx] : 8'h20;
         else    rd_exp = {(cyc <= m_busy_last), 7'(m_ac)};
      end
      bus.lcd_e = 1'b0;
      err_exp = m_apply(rs, rw, d, cyc + 3);
      errs = 0;
      repeat (4) begin
         @(negedge clk);
         if (cmd_err) errs++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (row1_val !== {16{8'h20}}) $display("FAIL rst_row1 got %h exp %h", row1_val, {16{8'h20}}); else n_pass++;
      n_checks++; if (rd_data_oe() !== 9'h000) $display("FAIL rst_rd got %h exp 000", rd_data_oe()); else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (row1_val !== {16{8'h20}}) $display("FAIL rel_row1 got %h", row1_val); else n_pass++;
      n_checks++; if (row2_val !== {16{8'h20}}) $display("FAIL rel_row2 got %h", row2_val); else n_pass++;
      n_checks++; if (addr !== 7'h00) $display("FAIL rel_addr got %h exp 00", addr); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rel_busy got %b exp 0", busy); else n_pass++;
      n_checks++; if ({disp_on, cursor_on, blink_on, cmd_err} !== 4'b0000) $display("FAIL rel_ctl got %b exp 0000", {disp_on, cursor_on, blink_on, cmd_err}); else n_pass++;
   endtask

   function automatic logic [8:0] rd_data_oe();
      return {bus.rd_oe, bus.rd_data};
   endfunction

   task automatic test_init_hi();
      logic [8:0] seq [8] = '{9'h038, 9'h008, 9'h001, 9'h006, 9'h00C, 9'h080, 9'h148, 9'h149};
      int errs, tot; bit ee; logic [7:0] rs_v, re_v;
      tot = 0;
      for (int i = 0; i < 8; i++) begin
         xfer(seq[i][8], 1'b0, seq[i][7:0], 3, errs, ee, rs_v, re_v);
         tot += errs;
         repeat (CLR_BUSY) @(negedge clk);
      end
      n_checks++; if (tot !== 0) $display("FAIL init_err got %0d exp 0", tot); else n_pass++;
      n_checks++; if (row1_val[127:112] !== 16'h4849) $display("FAIL init_hi got %h exp 4849", row1_val[127:112]); else n_pass++;
      n_checks++; if (addr !== 7'h02) $display("FAIL init_addr got %h exp 02", addr); else n_pass++;
      n_checks++; if ({disp_on, cursor_on} !== 2'b10) $display("FAIL init_dc got %b exp 10", {disp_on, cursor_on}); else n_pass++;
      n_checks++; if (row1_val !== m_row(0)) $display("FAIL init_row1 got %h exp %h", row1_val, m_row(0)); else n_pass++;
   endtask

   task automatic test_row2_fill();
      int errs; bit ee; logic [7:0] rs_v, re_v;
      xfer(1'b0, 1'b0, 8'hC0, 3, errs, ee, rs_v, re_v);
      repeat (8) @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         xfer(1'b1, 1'b0, 8'(8'h41 + i), 3, errs, ee, rs_v, re_v);
         repeat (4) @(negedge clk);
      end
      n_checks++; if (row2_val !== "ABCDEFGHIJKLMNOP") $display("FAIL row2_text got %h", row2_val); else n_pass++;
      n_checks++; if (addr !== 7'h51) $display("FAIL row2_addr got %h exp 51", addr); else n_pass++;
      n_checks++; if (row2_val !== m_row(1)) $display("FAIL row2_model got %h exp %h", row2_val, m_row(1)); else n_pass++;
   endtask

   task automatic test_busy_drop();
      int errs; bit ee; logic [7:0] rs_v, re_v;
      xfer(1'b0, 1'b0, 8'h01, 3, errs, ee, rs_v, re_v);
      xfer(1'b1, 1'b0, 8'h5A, 1, errs, ee, rs_v, re_v);
      n_checks++; if (errs !== 1 || !ee) $display("FAIL drop_err got %0d exp 1 (model %0d)", errs, ee); else n_pass++;
      n_checks++; if (row1_val !== {16{8'h20}}) $display("FAIL drop_row1 got %h", row1_val); else n_pass++;
      xfer(1'b0, 1'b1, 8'h00, 3, errs, ee, rs_v, re_v);
      n_checks++; if (rs_v !== 8'h80) $display("FAIL drop_bf got %h exp 80", rs_v); else n_pass++;
      n_checks++; if (rs_v !== re_v) $display("FAIL drop_bf_model got %h exp %h", rs_v, re_v); else n_pass++;
      n_checks++; if (errs !== 0) $display("FAIL drop_bf_err got %0d exp 0", errs); else n_pass++;
      repeat (CLR_BUSY) @(negedge clk);
   endtask

   task automatic test_entry_dec();
      int errs; bit ee; logic [7:0] rs_v, re_v; logic [6:0] a0;
      xfer(1'b0, 1'b0, 8'h04, 3, errs, ee, rs_v, re_v);
      xfer(1'b0, 1'b0, 8'h80, 3, errs, ee, rs_v, re_v);
      xfer(1'b1, 1'b0, 8'h58, 3, errs, ee, rs_v, re_v);
      repeat (4) @(negedge clk);
      n_checks++; if (row1_val[127:120] !== 8'h58) $display("FAIL dec_cell0 got %h exp 58", row1_val[127:120]); else n_pass++;
      n_checks++; if (addr !== 7'h67) $display("FAIL dec_addr got %h exp 67", addr); else n_pass++;
      xfer(1'b0, 1'b0, 8'h95, 3, errs, ee, rs_v, re_v);
      repeat (4) @(negedge clk);
      n_checks++; if (errs !== int'(ee) || addr !== 7'(m_ac)) $display("FAIL dec_95 got err %0d addr %h exp err %0d addr %h", errs, addr, ee, 7'(m_ac)); else n_pass++;
      a0 = addr;
      xfer(1'b0, 1'b0, 8'hE8, 3, errs, ee, rs_v, re_v);
      repeat (4) @(negedge clk);
      n_checks++; if (errs !== 1) $display("FAIL dec_e8_err got %0d exp 1", errs); else n_pass++;
      n_checks++; if (addr !== a0) $display("FAIL dec_e8_addr got %h exp %h", addr, a0); else n_pass++;
   endtask

   task automatic test_reset_busy();
      int errs; bit ee; logic [7:0] rs_v, re_v;
      xfer(1'b0, 1'b0, 8'h0F, 3, errs, ee, rs_v, re_v);
      xfer(1'b0, 1'b0, 8'h06, 3, errs, ee, rs_v, re_v);
      xfer(1'b0, 1'b0, 8'h80, 3, errs, ee, rs_v, re_v);
      xfer(1'b1, 1'b0, 8'h5A, 3, errs, ee, rs_v, re_v);
      n_checks++; if (busy !== 1'b1 || row1_val[127:120] !== 8'h5A) $display("FAIL rb_pre got busy %b cell %h exp 1 5a", busy, row1_val[127:120]); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0 || addr !== 7'h00 || cmd_err !== 1'b0) $display("FAIL rb_ctr got busy %b addr %h err %b exp 0 00 0", busy, addr, cmd_err); else n_pass++;
      n_checks++; if (row1_val !== {16{8'h20}} || row2_val !== {16{8'h20}}) $display("FAIL rb_rows got %h %h", row1_val, row2_val); else n_pass++;
      n_checks++; if ({disp_on, cursor_on, blink_on} !== 3'b000 || rd_data_oe() !== 9'h000) $display("FAIL rb_ctl got %b %h exp 000 000", {disp_on, cursor_on, blink_on}, rd_data_oe()); else n_pass++;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      xfer(1'b1, 1'b0, 8'h4B, 3, errs, ee, rs_v, re_v);
      repeat (4) @(negedge clk);
      n_checks++; if (errs !== 0 || row1_val[127:120] !== 8'h4B || addr !== 7'h01) $display("FAIL rb_next got err %0d cell %h addr %h exp 0 4b 01", errs, row1_val[127:120], addr); else n_pass++;
   endtask

   task automatic test_random();
      int errs, kind, hold; bit ee, rs, rw; logic [7:0] d, rs_v, re_v;
      for (int it = 0; it < 150; it++) begin
         kind = $urandom_range(0, 9);
         hold = 3;
         rs = 1'b0; rw = 1'b0;
         d = 8'($urandom_range(0, 255));
         if (kind <= 3) begin
            rs = 1'b1; d = 8'($urandom_range(8'h21, 8'h7E)); hold = $urandom_range(1, 3);
         end else if (kind <= 5) begin
            if ($urandom_range(0, 1) == 1) d = 8'h80 | 8'($urandom_range(0, 1) * 64 + $urandom_range(0, 15));
            hold = $urandom_range(1, 3);
         end else if (kind <= 7) begin
            rw = 1'b1;
         end else begin
            rs = 1'b1; rw = 1'b1;
         end
         xfer(rs, rw, d, hold, errs, ee, rs_v, re_v);
         n_checks++; if (errs !== int'(ee)) $display("FAIL rnd_err it %0d d %h got %0d exp %0d", it, d, errs, ee); else n_pass++;
         n_checks++; if (rs_v !== re_v) $display("FAIL rnd_rd it %0d got %h exp %h", it, rs_v, re_v); else n_pass++;
         repeat ($urandom_range(0, 20)) @(negedge clk);
         n_checks++; if (addr !== 7'(m_ac)) $display("FAIL rnd_addr it %0d got %h exp %h", it, addr, 7'(m_ac)); else n_pass++;
         n_checks++; if (row1_val !== m_row(0) || row2_val !== m_row(1)) $display("FAIL rnd_rows it %0d got %h %h", it, row1_val, row2_val); else n_pass++;
         n_checks++; if ({disp_on, cursor_on, blink_on} !== {m_d, m_c, m_b}) $display("FAIL rnd_dcb it %0d got %b exp %b", it, {disp_on, cursor_on, blink_on}, {m_d, m_c, m_b}); else n_pass++;
         n_checks++; if (busy !== (cyc <= m_busy_last)) $display("FAIL rnd_busy it %0d got %b exp %b", it, busy, (cyc <= m_busy_last)); else n_pass++;
      end
   endtask

   initial begin
      bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data = 8'h00;
      test_reset();
      test_init_hi();
      test_row2_fill();
      test_busy_drop();
      test_entry_dec();
      test_reset_busy();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
